// File: rtl/tt_uart_tx_pkg.sv
// tt_uart_pkg: shared types and constants for the UART transmit path.
//   state_t      - transmit FSM state, 3-bit encoding
//   PAR_*        - parity-mode selector values for the PARITY parameter
//   frame_bits() - serial bits per frame (start + 8 data + optional parity + stop)
package tt_uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    function automatic int unsigned frame_bits(int unsigned parity);
        return (parity == PAR_NONE) ? 10 : 11;
    endfunction

endpackage

// File: rtl/tt_uart_tx_if.sv
// tt_uart_tx_if: byte handshake between the producer and the UART transmitter.
//   data_in - byte to transmit, meaningful when valid
//   valid   - producer offers a byte
//   ready   - transmitter accepts a byte this cycle
// A transfer happens on a rising clock edge with valid && ready.
interface tt_uart_tx_if;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;

    modport master (output data_in, output valid, input ready);
    modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/tt_uart_tx_baud_tick.sv
// tt_baud_tick: bit-period timer for the UART transmitter.
//   clk, rst_n - clock, asynchronous active-low reset
//   run        - count enable; the counter is held at zero while low
//   tick       - high on the last cycle of each CLKS_PER_BIT-cycle bit period
module tt_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] Terminal = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == Terminal);

    always_comb begin
        cnt_d = cnt_q;
        if (!run || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_uart_tx.sv
// tt_uart_tx: serialises bytes as UART frames (start, 8 data LSB first,
// optional parity, 1 stop) onto a single pin.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave side of the byte handshake (data_in, valid, ready)
//   tx         - registered serial output, idles high
//   busy       - high from the first start cycle through the last stop cycle
module tt_uart_tx
    import tt_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    tt_uart_tx_if.slave    bus,
    output logic           tx,
    output logic           busy
);

    if (PARITY > PAR_ODD) begin : g_bad_parity
        $error("tt_uart_tx: PARITY must be 0 (none), 1 (even) or 2 (odd)");
    end
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 4095) begin : g_bad_div
        $error("tt_uart_tx: CLKS_PER_BIT must be in 2..4095");
    end

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       parity_q, parity_d;
    logic       tx_q, tx_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       tick;
    logic       accept;

    tt_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (state_q != StIdle),
        .tick (tick)
    );

    // ready_q is low for the first cycle out of reset even though the FSM is idle.
    assign accept = bus.valid && ready_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d  = bus.data_in;
                    parity_d = (PARITY == PAR_ODD) ? ~^bus.data_in : ^bus.data_in;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (tick) state_d = StData;
            end
            StData: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (tick) state_d = StStop;
            end
            StStop: begin
                if (tick) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so tx has no input-to-pin path.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.ready = ready_q;
    assign tx        = tx_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tt_uart_tx.sv
// tb_tt_uart_tx: four transmitter instances (div 4 / no parity, div 4 / even,
// div 4 / odd, div 2 / no parity) share one stimulus stream. Each has a
// frame-level reference model and a per-cycle compare; directed frames are
// additionally pinned against hand-computed bit patterns.
module tb_tt_uart_tx;

    localparam int NI = 4;
    localparam int CAP = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;

    logic tx_w [NI];
    logic rdy_w [NI];
    logic busy_w [NI];

    logic cap_tx [NI][CAP];
    logic cap_rdy [NI][CAP];
    logic cap_busy [NI][CAP];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    endtask

    // Frame as a bit list, index 0 sent first.
    function automatic logic [10:0] frame_of(input logic [7:0] d, input int unsigned p);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) f[k+1] = d[k];
        if (p == 1) f[9] = ^d;
        else if (p == 2) f[9] = ~^d;
        return f;
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int unsigned C  = (gi == 3) ? 2 : 4;
        localparam int unsigned P  = (gi == 1) ? 1 : ((gi == 2) ? 2 : 0);
        localparam int unsigned NB = (P == 0) ? 10 : 11;

        tt_uart_tx_if u_if ();
        logic tx;
        logic busy;

        assign u_if.valid   = valid;
        assign u_if.data_in = data;

        tt_uart_tx #(
            .CLKS_PER_BIT(C),
            .PARITY      (P)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (u_if.slave),
            .tx   (tx),
            .busy (busy)
        );

        assign tx_w[gi]   = tx;
        assign rdy_w[gi]  = u_if.ready;
        assign busy_w[gi] = busy;

        // Model: rem = cycles of the current frame still to send (0 = idle).
        int unsigned rem = 0;
        logic        m_rdy = 1'b0;
        logic [10:0] m_bits = '1;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rem   <= 0;
                m_rdy <= 1'b0;
            end else if (rem > 0) begin
                rem <= rem - 1;
                if (rem == 1) m_rdy <= 1'b1;
            end else if (m_rdy && valid) begin
                m_bits <= frame_of(data, P);
                rem    <= NB * C;
                m_rdy  <= 1'b0;
            end else begin
                m_rdy <= 1'b1;
            end
        end

        always @(negedge clk) begin
            check($sformatf("i%0d_tx", gi), tx,
                  (rem == 0) ? 1'b1 : m_bits[(NB * C - rem) / C]);
            check($sformatf("i%0d_busy", gi), busy, (rem != 0));
            check($sformatf("i%0d_ready", gi), u_if.ready, m_rdy);
        end
    end

    function automatic int frame_vec(input int i, input int c, input int nb, input int off);
        int v;
        v = 0;
        for (int j = 0; j < nb; j++) if (cap_tx[i][off + j * c + c / 2] === 1'b1) v |= (1 << j);
        return v;
    endfunction

    function automatic int busy_count(input int i, input int n);
        int v;
        v = 0;
        for (int k = 0; k < n; k++) if (cap_busy[i][k] === 1'b1) v++;
        return v;
    endfunction

    task automatic wait_ready();
        bit ok;
        ok    = 1'b0;
        valid = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            ok = rdy_w[0] && rdy_w[1] && rdy_w[2] && rdy_w[3];
        end
        check("ready_wait", ok, 1);
    endtask

    // Offers byte d to all instances once all are ready, then captures n cycles;
    // index 0 is the first cycle of the frame.
    task automatic run_frame(input logic [7:0] d, input int n, input int chg_at,
                             input logic [7:0] chg_d, input int drop_at);
        wait_ready();
        valid = 1'b1;
        data  = d;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                cap_tx[i][k]   = tx_w[i];
                cap_rdy[i][k]  = rdy_w[i];
                cap_busy[i][k] = busy_w[i];
            end
            if (k == chg_at) begin
                valid = 1'b1;
                data  = chg_d;
            end
            if (k == drop_at) valid = 1'b0;
        end
    endtask

    initial begin
        bit ok;

        // Reset values and the first ready edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", tx_w[0], 1);
        check("rst_ready", rdy_w[0], 0);
        check("rst_busy", busy_w[0], 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("ready_before_edge", rdy_w[0], 0);
        @(negedge clk);
        check("ready_after_edge", rdy_w[0], 1);

        // Basic frame and parity variants with 0xA5.
        run_frame(8'hA5, 45, -1, 8'h00, 0);
        check("a5_bits_i0", frame_vec(0, 4, 10, 0), 842);
        check("a5_busy_i0", busy_count(0, 45), 40);
        check("a5_ready39_i0", cap_rdy[0][39], 0);
        check("a5_ready40_i0", cap_rdy[0][40], 1);
        check("a5_bits_even", frame_vec(1, 4, 11, 0), 1354);
        check("a5_busy_even", busy_count(1, 45), 44);
        check("a5_bits_odd", frame_vec(2, 4, 11, 0), 1866);
        check("a5_bits_div2", frame_vec(3, 2, 10, 0), 842);

        run_frame(8'h07, 45, -1, 8'h00, 0);
        check("07_bits_odd", frame_vec(2, 4, 11, 0), 1038);

        // Back-to-back 0x00 then 0xFF with valid held high.
        run_frame(8'h00, 82, 0, 8'hFF, 41);
        check("b2b_f1", frame_vec(0, 4, 10, 0), 512);
        check("b2b_gap_tx", cap_tx[0][40], 1);
        check("b2b_gap_ready", cap_rdy[0][40], 1);
        check("b2b_gap_busy", cap_busy[0][40], 0);
        check("b2b_f2", frame_vec(0, 4, 10, 41), 1022);

        // New data offered mid-frame is held off until the next ready.
        run_frame(8'h3C, 82, 5, 8'hFF, 41);
        check("hold_bits", frame_vec(0, 4, 10, 0), 632);
        check("hold_ready39", cap_rdy[0][39], 0);
        check("hold_next", frame_vec(0, 4, 10, 41), 1022);

        // Asynchronous reset during data bit 3.
        run_frame(8'hF0, 18, -1, 8'h00, 0);
        check("mid_pre_tx", cap_tx[0][17], 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx_w[0], 1);
        check("mid_rst_ready", rdy_w[0], 0);
        check("mid_rst_busy", busy_w[0], 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_ready", rdy_w[0], 1);
        run_frame(8'h81, 45, -1, 8'h00, 0);
        check("post_rst_81", frame_vec(0, 4, 10, 0), 770);

        // valid high during reset must not start a frame.
        #2 rst_n = 1'b0;
        valid = 1'b1;
        data  = 8'hAA;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rstv_tx", tx_w[0], 1);
            check("rstv_ready", rdy_w[0], 0);
        end
        valid = 1'b0;
        #2 rst_n = 1'b1;

        // Minimum divider: every bit exactly 2 cycles.
        run_frame(8'h55, 45, -1, 8'h00, 0);
        check("div2_bits", frame_vec(3, 2, 10, 0), 682);
        check("div2_busy", busy_count(3, 45), 20);
        ok = 1'b1;
        for (int j = 0; j < 10; j++) begin
            if (cap_tx[3][2 * j] !== cap_tx[3][2 * j + 1]) ok = 1'b0;
            if (j < 9 && cap_tx[3][2 * j] === cap_tx[3][2 * j + 2]) ok = 1'b0;
        end
        check("div2_width", ok, 1);

        // Random traffic with occasional resets; the per-cycle compare does the checking.
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 3) != 0);
            data  = 8'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        valid = 1'b0;
        repeat (60) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tt_uart_tx.md
Name: tt_uart_tx

Overview:
Transmit end of the design's byte path. The design computes its result in parallel on-chip; this block serialises result bytes onto a single pin as UART frames (start, 8 data bits LSB first, optional parity, 1 stop). Bytes arrive through a valid/ready handshake. It sits between the arithmetic core and one uo_out pin of the tt_um top.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..4095.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd; other values are illegal (elaboration-time assertion).

Ports:
clk  input  1  single system clock; all logic on its rising edge
rst_n  input  1  reset, asynchronous assert, active-low
data_in  input  8  byte to transmit; sampled only on an accepted transfer
valid  input  1  producer has a byte on data_in
ready  output  1  block can accept a byte this cycle
tx  output  1  serial line; idles high
busy  output  1  frame in progress (start through stop)

Behaviour:
- Clocking and reset: one clock; rst_n is asynchronous and active-low.
- Reset values while rst_n is low: tx=1, ready=0, busy=0; state IDLE; bit and cycle counters 0.
- ready is registered. It rises on the first clk edge with rst_n high and is 1 whenever the block is in IDLE after reset.
- Transfer occurs on a rising edge where valid && ready. data_in is latched into the shift register, and parity is computed from the latched byte.
- Acceptance cycle: ready=0 and state=START from the next edge. valid/data_in are ignored until ready returns.
- FSM states: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
- Bit timing: each state after IDLE drives tx for exactly CLKS_PER_BIT cycles.
  - START: tx=0.
  - DATA: tx=shift[0]; shift right each bit; bit index 0..7; leave after index 7 completes.
  - PARITY: tx = XOR(byte) for even; ~XOR(byte) for odd.
  - STOP: tx=1.
- Frame length: 10 bits (11 with parity). The frame begins on the cycle after acceptance and lasts exactly N*CLKS_PER_BIT cycles.
- busy=1 from the first START cycle through the last STOP cycle inclusive.
- End of frame: on the last STOP cycle's edge, the FSM enters IDLE with ready=1 and busy=0. With valid held high, the next byte is accepted that cycle, so there is exactly one idle-high cycle between frames.
- Cycle counter: width clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 and wraps; a bit ends at terminal count. Bit index is a 3-bit counter and wraps 7 -> 0 with no overflow.
- Reset mid-frame: tx forced to 1 immediately (asynchronous). The frame is abandoned and the byte is not resent.
- valid deasserted after acceptance: no effect. Nothing is queued; the block holds no buffer beyond the one shift register.
- tx is a registered output: no glitches, no combinational path from any input.

Decomposition:
- Package tt_uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding.
  - parity-mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - function to compute frame bit count from the parity mode.
- Sub-module tt_baud_tick (parameter CLKS_PER_BIT):
  - Ports: clk, rst_n, run, tick.
  - Counter cleared while run=0; tick asserts on terminal count.
  - The FSM advances bit and state only on tick.

Test Plan:
1. Basic frame, CLKS_PER_BIT=4, PARITY=0. Send 0xA5 -> tx holds each level 4 cycles: 0,1,0,1,0,0,1,0,1,1 (40 cycles); busy high 40 cycles; ready returns on cycle 41.
2. Parity. PARITY=1, send 0xA5 -> parity bit 0, frame 44 cycles. PARITY=2, send 0x07 -> parity bit 0; send 0xA5 -> parity bit 1.
3. Back-to-back. valid held high with 0x00 then 0xFF, CLKS_PER_BIT=4, PARITY=0 -> frame 1 is all-low data; exactly 1 idle-high cycle; frame 2 is all-high data; both accepted with no loss.
4. Data change while busy. Accept 0x3C, then drive data_in=0xFF with valid=1 mid-frame -> serial data stays 0x3C (0,0,1,1,1,1,0,0); 0xFF is accepted only at the next ready.
5. Reset mid-frame. Assert rst_n low during data bit 3 -> tx=1 and ready=0 in the same cycle without a clock edge. After release, ready=1 after one edge; a new byte 0x81 transmits correctly.
6. Reset and minimum divider.
   - rst_n low with valid=1 -> no acceptance and tx stays 1.
   - CLKS_PER_BIT=2, send 0x55 -> 20-cycle frame; every bit is exactly 2 cycles wide.
